// File: rtl/common_library.sv
// Shared RV32I decode constants and control-word encodings.
// Holds the opcode and funct3/funct7 values, the datapath select encodings
// and the packed control word used by control_unit.
package common_library;

    // Major opcodes (instr[6:0])
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    // funct3 values
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_LB      = 3'b000;
    localparam logic [2:0] F3_LH      = 3'b001;
    localparam logic [2:0] F3_LW      = 3'b010;
    localparam logic [2:0] F3_LBU     = 3'b100;
    localparam logic [2:0] F3_LHU     = 3'b101;
    localparam logic [2:0] F3_SB      = 3'b000;
    localparam logic [2:0] F3_SH      = 3'b001;
    localparam logic [2:0] F3_SW      = 3'b010;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;
    localparam logic [2:0] F3_BLT     = 3'b100;
    localparam logic [2:0] F3_BGE     = 3'b101;
    localparam logic [2:0] F3_BLTU    = 3'b110;
    localparam logic [2:0] F3_BGEU    = 3'b111;
    localparam logic [2:0] F3_JALR    = 3'b000;

    // funct7 values
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Register-file write source
    typedef enum logic [1:0] {
        RF_W_ALU  = 2'b00,
        RF_W_MEM  = 2'b01,
        RF_W_PC4  = 2'b10,
        RF_W_UIMM = 2'b11
    } rf_w_sel_e;

    // ALU operand A
    typedef enum logic {
        MUX1_RS1 = 1'b0,
        MUX1_PC  = 1'b1
    } mux1_sel_e;

    // ALU operand B (2'b11 reserved, never produced)
    typedef enum logic [1:0] {
        MUX2_RS2    = 2'b00,
        MUX2_IMM    = 2'b01,
        MUX2_CONST4 = 2'b10
    } mux2_sel_e;

    // ALU operation class (3'b101..3'b111 never produced)
    typedef enum logic [2:0] {
        ALU_ADD    = 3'b000,
        ALU_R      = 3'b001,
        ALU_I      = 3'b010,
        ALU_BRANCH = 3'b011,
        ALU_PASS_B = 3'b100
    } alu_op_e;

    // Next-PC target base
    typedef enum logic {
        PC_SEL_PC_IMM = 1'b0,
        PC_SEL_ALU    = 1'b1
    } pc_sel_e;

    // Registered control word
    typedef struct packed {
        rf_w_sel_e  rf_w_select;
        mux1_sel_e  alu_mux1_select;
        mux2_sel_e  alu_mux2_select;
        alu_op_e    alu_op_select;
        pc_sel_e    alu_pc_select;
        logic       w_en_rf;
        logic       wr_en_dmem;
        logic [1:0] rw_mode;
        logic       branch;
        logic       jump;
    } ctrl_t;

    localparam ctrl_t CTRL_DEFAULT = '{
        rf_w_select:     RF_W_ALU,
        alu_mux1_select: MUX1_RS1,
        alu_mux2_select: MUX2_RS2,
        alu_op_select:   ALU_ADD,
        alu_pc_select:   PC_SEL_PC_IMM,
        w_en_rf:         1'b0,
        wr_en_dmem:      1'b0,
        rw_mode:         2'b00,
        branch:          1'b0,
        jump:            1'b0
    };

endpackage

// File: rtl/control_unit.sv
// control_unit: RV32I main decoder with a registered control word.
// Decodes opcode/funct3/funct7/rd combinationally and registers the result,
// so every control output follows instr by exactly one clk cycle.
// Ports:
//   clk, rst_n       rising-edge clock, asynchronous active-low reset
//   instr[31:0]      instruction word under decode
//   rf_w_select[1:0] register-file write source
//   alu_mux1_select  ALU operand A select
//   alu_mux2_select  ALU operand B select
//   alu_op_select    ALU operation class
//   alu_pc_select    next-PC target base
//   w_en_rf          register-file write enable
//   w_en_pmem        program-memory write enable (always 0)
//   wr_en_dmem       data-memory write enable
//   rw_mode[1:0]     data-memory access width
//   branch, jump     control-flow flags
module control_unit
    import common_library::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    output logic [1:0]  rf_w_select,
    output logic        alu_mux1_select,
    output logic [1:0]  alu_mux2_select,
    output logic [2:0]  alu_op_select,
    output logic        alu_pc_select,
    output logic        w_en_rf,
    output logic        w_en_pmem,
    output logic        wr_en_dmem,
    output logic [1:0]  rw_mode,
    output logic        branch,
    output logic        jump
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd;
    logic       unused_fields;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign rd     = instr[11:7];
    // Register/immediate fields are consumed by the datapath, not here.
    assign unused_fields = ^instr[24:15];

    ctrl_t ctrl_d;
    ctrl_t ctrl_q;
    logic  reg_write_only;

    always_comb begin
        ctrl_d         = CTRL_DEFAULT;
        reg_write_only = 1'b0;
        // Every legal opcode ends in 2'b11, so unknown opcodes and
        // instr[1:0] != 2'b11 both fall through to the default word.
        case (opcode)
            OP_R: begin
                if (funct7 == F7_BASE ||
                    (funct7 == F7_ALT && (funct3 == F3_ADD_SUB || funct3 == F3_SRL_SRA))) begin
                    ctrl_d.alu_mux2_select = MUX2_RS2;
                    ctrl_d.alu_op_select   = ALU_R;
                    ctrl_d.rf_w_select     = RF_W_ALU;
                    ctrl_d.w_en_rf         = 1'b1;
                    reg_write_only         = 1'b1;
                end
            end
            OP_I: begin
                // Only the shift forms constrain funct7.
                if (!(funct3 == F3_SLL && funct7 != F7_BASE) &&
                    !(funct3 == F3_SRL_SRA && funct7 != F7_BASE && funct7 != F7_ALT)) begin
                    ctrl_d.alu_mux2_select = MUX2_IMM;
                    ctrl_d.alu_op_select   = ALU_I;
                    ctrl_d.rf_w_select     = RF_W_ALU;
                    ctrl_d.w_en_rf         = 1'b1;
                    reg_write_only         = 1'b1;
                end
            end
            OP_LOAD: begin
                if (funct3 == F3_LB || funct3 == F3_LH || funct3 == F3_LW ||
                    funct3 == F3_LBU || funct3 == F3_LHU) begin
                    ctrl_d.alu_mux2_select = MUX2_IMM;
                    ctrl_d.alu_op_select   = ALU_ADD;
                    ctrl_d.rf_w_select     = RF_W_MEM;
                    ctrl_d.w_en_rf         = 1'b1;
                    ctrl_d.rw_mode         = funct3[1:0];
                end
            end
            OP_S: begin
                if (funct3 == F3_SB || funct3 == F3_SH || funct3 == F3_SW) begin
                    ctrl_d.alu_mux2_select = MUX2_IMM;
                    ctrl_d.alu_op_select   = ALU_ADD;
                    ctrl_d.wr_en_dmem      = 1'b1;
                    ctrl_d.rw_mode         = funct3[1:0];
                end
            end
            OP_B: begin
                if (funct3 == F3_BEQ || funct3 == F3_BNE || funct3 == F3_BLT ||
                    funct3 == F3_BGE || funct3 == F3_BLTU || funct3 == F3_BGEU) begin
                    ctrl_d.alu_mux1_select = MUX1_RS1;
                    ctrl_d.alu_mux2_select = MUX2_RS2;
                    ctrl_d.alu_op_select   = ALU_BRANCH;
                    ctrl_d.branch          = 1'b1;
                    ctrl_d.alu_pc_select   = PC_SEL_PC_IMM;
                end
            end
            OP_JAL: begin
                ctrl_d.rf_w_select     = RF_W_PC4;
                ctrl_d.w_en_rf         = 1'b1;
                ctrl_d.jump            = 1'b1;
                ctrl_d.alu_pc_select   = PC_SEL_PC_IMM;
                ctrl_d.alu_mux1_select = MUX1_PC;
                ctrl_d.alu_mux2_select = MUX2_IMM;
                ctrl_d.alu_op_select   = ALU_ADD;
            end
            OP_JALR: begin
                if (funct3 == F3_JALR) begin
                    ctrl_d.rf_w_select     = RF_W_PC4;
                    ctrl_d.w_en_rf         = 1'b1;
                    ctrl_d.jump            = 1'b1;
                    ctrl_d.alu_pc_select   = PC_SEL_ALU;
                    ctrl_d.alu_mux1_select = MUX1_RS1;
                    ctrl_d.alu_mux2_select = MUX2_IMM;
                    ctrl_d.alu_op_select   = ALU_ADD;
                end
            end
            OP_LUI: begin
                ctrl_d.rf_w_select     = RF_W_UIMM;
                ctrl_d.alu_mux2_select = MUX2_IMM;
                ctrl_d.alu_op_select   = ALU_PASS_B;
                ctrl_d.w_en_rf         = 1'b1;
                reg_write_only         = 1'b1;
            end
            OP_AUIPC: begin
                ctrl_d.alu_mux1_select = MUX1_PC;
                ctrl_d.alu_mux2_select = MUX2_IMM;
                ctrl_d.alu_op_select   = ALU_ADD;
                ctrl_d.rf_w_select     = RF_W_ALU;
                ctrl_d.w_en_rf         = 1'b1;
                reg_write_only         = 1'b1;
            end
            default: ctrl_d = CTRL_DEFAULT;
        endcase

        // x0 is never written. Classes whose only effect is that write
        // (R, I-ALU, LUI, AUIPC) collapse to the idle word, so the canonical
        // NOP decodes to all zeros; loads and jumps keep their other fields.
        if (rd == 5'd0) begin
            if (reg_write_only) begin
                ctrl_d = CTRL_DEFAULT;
            end else begin
                ctrl_d.w_en_rf = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q <= CTRL_DEFAULT;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    assign rf_w_select     = ctrl_q.rf_w_select;
    assign alu_mux1_select = ctrl_q.alu_mux1_select;
    assign alu_mux2_select = ctrl_q.alu_mux2_select;
    assign alu_op_select   = ctrl_q.alu_op_select;
    assign alu_pc_select   = ctrl_q.alu_pc_select;
    assign w_en_rf         = ctrl_q.w_en_rf;
    assign w_en_pmem       = 1'b0;
    assign wr_en_dmem      = ctrl_q.wr_en_dmem;
    assign rw_mode         = ctrl_q.rw_mode;
    assign branch          = ctrl_q.branch;
    assign jump            = ctrl_q.jump;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: self-checking bench for control_unit.
// Expected control words are pushed when an instruction is driven and
// compared one clock edge later when the registered outputs appear.
module tb_control_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic [1:0]  rf_w_select;
    logic        alu_mux1_select;
    logic [1:0]  alu_mux2_select;
    logic [2:0]  alu_op_select;
    logic        alu_pc_select;
    logic        w_en_rf;
    logic        w_en_pmem;
    logic        wr_en_dmem;
    logic [1:0]  rw_mode;
    logic        branch;
    logic        jump;

    control_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .instr           (instr),
        .rf_w_select     (rf_w_select),
        .alu_mux1_select (alu_mux1_select),
        .alu_mux2_select (alu_mux2_select),
        .alu_op_select   (alu_op_select),
        .alu_pc_select   (alu_pc_select),
        .w_en_rf         (w_en_rf),
        .w_en_pmem       (w_en_pmem),
        .wr_en_dmem      (wr_en_dmem),
        .rw_mode         (rw_mode),
        .branch          (branch),
        .jump            (jump)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- observed word ----------------
    logic [15:0] obs;
    assign obs = {rf_w_select, alu_mux1_select, alu_mux2_select, alu_op_select,
                  alu_pc_select, w_en_rf, w_en_pmem, wr_en_dmem, rw_mode,
                  branch, jump};

    // Expected word built from individual field values.
    function automatic logic [15:0] cw(input logic [1:0] rf, input logic m1,
                                       input logic [1:0] m2, input logic [2:0] op,
                                       input logic pcs, input logic wrf,
                                       input logic wdm, input logic [1:0] rw,
                                       input logic br, input logic jp);
        return {rf, m1, m2, op, pcs, wrf, 1'b0, wdm, rw, br, jp};
    endfunction

    // ---------------- scoreboard ----------------
    logic [15:0] exp_q[$];
    string       tag_q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Compare once per cycle, just after the edge that registered the word.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            logic [15:0] e;
            string       t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check_eq(t, {16'h0, obs}, {16'h0, e});
        end
    end

    // ---------------- driver ----------------
    task automatic drive_instr(input string tag, input logic [31:0] i, input logic [15:0] e);
        @(posedge clk);
        #2;
        instr = i;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    // Common expected words
    logic [15:0] w_r, w_lw, w_sw;
    initial begin
        w_r  = cw(2'b00, 1'b0, 2'b00, 3'b001, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        w_lw = cw(2'b01, 1'b0, 2'b01, 3'b000, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0);
        w_sw = cw(2'b00, 1'b0, 2'b01, 3'b000, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0);
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] r;
        rst_n = 1'b0;
        instr = 32'h00418133;
        #3;
        check_eq("reset_async_t0", {16'h0, obs}, 32'h0);
        @(posedge clk);
        #1;
        check_eq("reset_hold_edge", {16'h0, obs}, 32'h0);
        #2;
        rst_n = 1'b1;
        #1;
        check_eq("reset_release_no_edge", {16'h0, obs}, 32'h0);
        exp_q.push_back(w_r);
        tag_q.push_back("first_after_reset");

        // Directed vectors
        drive_instr("add",   32'h00418133, w_r);
        drive_instr("lw",    32'h00822183, w_lw);
        drive_instr("sw",    32'h0041A623, w_sw);
        drive_instr("bge",   32'h0041D663, cw(2'b00, 1'b0, 2'b00, 3'b011, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0));
        drive_instr("jal",   32'h050001EF, cw(2'b10, 1'b1, 2'b01, 3'b000, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1));
        drive_instr("jalr",  32'h078201E7, cw(2'b10, 1'b0, 2'b01, 3'b000, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1));
        drive_instr("lui",   32'h00002537, cw(2'b11, 1'b0, 2'b01, 3'b100, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0));
        drive_instr("auipc", 32'h00002797, cw(2'b00, 1'b1, 2'b01, 3'b000, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0));
        drive_instr("zero_word", 32'h00000000, 16'h0);
        drive_instr("nop_addi",  32'h00000013, 16'h0);
        drive_instr("sub",       32'h403100B3, w_r);
        drive_instr("srai",      32'h40315093, cw(2'b00, 1'b0, 2'b01, 3'b010, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0));
        drive_instr("lb_width",  32'h00820183, cw(2'b01, 1'b0, 2'b01, 3'b000, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0));
        drive_instr("lhu_width", 32'h00825183, cw(2'b01, 1'b0, 2'b01, 3'b000, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0));
        drive_instr("lw_rd0",    32'h00822003, cw(2'b01, 1'b0, 2'b01, 3'b000, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0));
        drive_instr("jal_rd0",   32'h0500006F, cw(2'b10, 1'b1, 2'b01, 3'b000, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1));
        // Illegal encodings
        drive_instr("ill_r_f7alt_f3", 32'h403110B3, 16'h0);
        drive_instr("ill_slli_f7",    32'h40311093, 16'h0);
        drive_instr("ill_load_f3",    32'h00823183, 16'h0);
        drive_instr("ill_store_f3",   32'h0041B623, 16'h0);
        drive_instr("ill_branch_f3",  32'h0041A663, 16'h0);
        drive_instr("ill_jalr_f3",    32'h078211E7, 16'h0);
        drive_instr("ill_r_f7",       32'h02418133, 16'h0);

        // Random: low bits not 11 always decode idle
        for (int k = 0; k < 8; k++) begin
            r = $urandom;
            r[1:0] = 2'($urandom_range(0, 2));
            drive_instr("rand_bad_low", r, 16'h0);
        end
        // Random base R-type with nonzero rd
        for (int k = 0; k < 8; k++) begin
            r = {7'b0000000, 10'($urandom_range(0, 1023)), 3'($urandom_range(0, 7)),
                 5'($urandom_range(1, 31)), 7'b0110011};
            drive_instr("rand_r", r, w_r);
        end

        // Reset asserted mid-stream between edges
        drive_instr("pre_reset_lw", 32'h00822183, w_lw);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("midreset_async", {16'h0, obs}, 32'h0);
        @(posedge clk);
        #1;
        check_eq("midreset_hold", {16'h0, obs}, 32'h0);
        #2;
        rst_n = 1'b1;
        #1;
        check_eq("midreset_release_no_edge", {16'h0, obs}, 32'h0);
        exp_q.push_back(w_lw);
        tag_q.push_back("midreset_first_edge");
        drive_instr("post_reset_sw", 32'h0041A623, w_sw);

        // Drain with a bounded wait
        for (int k = 0; k < 5 && exp_q.size() > 0; k++) begin
            @(posedge clk);
            #2;
        end
        check_eq("queue_drained", exp_q.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
